// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into click / double click / long press,
// with auto-repeat ticks while a long press is held. One shared interval counter.
module button_event_classifier #(
   parameter int LONG_CYCLES   = 50000000,
   parameter int GAP_CYCLES    = 12500000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_BITS      = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_level,
   output logic click,
   output logic dbl_click,
   output logic long_press,
   output logic repeat_tick,
   output logic busy
);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      WAIT_SECOND,
      SECOND_PRESSED,
      LONG_HELD,
      WAIT_RELEASE
   } state_t;

   localparam logic [CNT_BITS-1:0] LONG_LAST   = CNT_BITS'(LONG_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] GAP_LAST    = CNT_BITS'(GAP_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                click_q, click_d;
   logic                dbl_click_q, dbl_click_d;
   logic                long_press_q, long_press_d;
   logic                repeat_tick_q, repeat_tick_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         click_q       <= 1'b0;
         dbl_click_q   <= 1'b0;
         long_press_q  <= 1'b0;
         repeat_tick_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         click_q       <= click_d;
         dbl_click_q   <= dbl_click_d;
         long_press_q  <= long_press_d;
         repeat_tick_q <= repeat_tick_d;
      end
   end

   // Release / second-press branches are tested first so they win over an
   // interval expiring on the same edge.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      click_d       = 1'b0;
      dbl_click_d   = 1'b0;
      long_press_d  = 1'b0;
      repeat_tick_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (btn_level) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end
         end
         PRESSED: begin
            if (!btn_level) begin
               state_d = WAIT_SECOND;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               long_press_d = 1'b1;
               state_d      = LONG_HELD;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_SECOND: begin
            if (btn_level) begin
               state_d = SECOND_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               click_d = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SECOND_PRESSED: begin
            if (!btn_level) begin
               dbl_click_d = 1'b1;
               state_d     = IDLE;
               cnt_d       = '0;
            end else if (cnt_q == LONG_LAST) begin
               dbl_click_d = 1'b1;
               state_d     = WAIT_RELEASE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LONG_HELD: begin
            if (!btn_level) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
               repeat_tick_d = 1'b1;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (!btn_level) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign click       = click_q;
   assign dbl_click   = dbl_click_q;
   assign long_press  = long_press_q;
   assign repeat_tick = repeat_tick_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_button_event_classifier.sv
// Randomized and directed bench for button_event_classifier; reference model
// works on run lengths of the sampled button level.
module tb_button_event_classifier;

   localparam int LONG   = 8;
   localparam int GAP    = 4;
   localparam int REPEAT = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_level = 1'b0;
   logic click, dbl_click, long_press, repeat_tick, busy;

   int n_cmp = 0;
   int n_err = 0;

   // run-length reference model
   bit in_g, high_run, long_held, wait_rel;
   int run, presses;
   logic e_click, e_dbl, e_long, e_rep, e_busy;

   // observed pulse counts, cleared per scenario
   int o_click, o_dbl, o_long, o_rep;

   button_event_classifier #(
      .LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REPEAT), .CNT_BITS(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
      .click(click), .dbl_click(dbl_click), .long_press(long_press),
      .repeat_tick(repeat_tick), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      in_g = 0; high_run = 0; long_held = 0; wait_rel = 0;
      run = 0; presses = 0;
      e_click = 0; e_dbl = 0; e_long = 0; e_rep = 0; e_busy = 0;
   endtask

   task automatic model_step(input logic b);
      e_click = 0; e_dbl = 0; e_long = 0; e_rep = 0;
      if (!in_g) begin
         if (b) begin
            in_g = 1; presses = 1; high_run = 1; run = 1;
            long_held = 0; wait_rel = 0;
         end
      end else if (high_run) begin
         if (b) begin
            run++;
            if (wait_rel) begin
            end else if (long_held) begin
               if ((run - LONG - 1) % REPEAT == 0) e_rep = 1;
            end else if (run == LONG + 1) begin
               if (presses == 1) begin e_long = 1; long_held = 1; end
               else begin e_dbl = 1; wait_rel = 1; end
            end
         end else begin
            if (long_held || wait_rel) in_g = 0;
            else if (presses == 2) begin e_dbl = 1; in_g = 0; end
            else begin high_run = 0; run = 1; end
         end
      end else begin
         if (b) begin presses = 2; high_run = 1; run = 1; end
         else begin
            run++;
            if (run == GAP + 1) begin e_click = 1; in_g = 0; end
         end
      end
      e_busy = in_g;
   endtask

   // one clock with btn held at level; compare on the following +1 time unit
   task automatic step(input logic level);
      btn_level = level;
      @(posedge clk);
      if (rst_n) model_step(level);
      #1;
      check_eq("outputs", {click, dbl_click, long_press, repeat_tick, busy},
               {e_click, e_dbl, e_long, e_rep, e_busy});
      check_eq("onehot", 32'($countones({click, dbl_click, long_press, repeat_tick}) <= 1), 32'd1);
      o_click += int'(click); o_dbl += int'(dbl_click);
      o_long  += int'(long_press); o_rep += int'(repeat_tick);
   endtask

   task automatic drive(input logic level, input int n);
      for (int i = 0; i < n; i++) step(level);
   endtask

   task automatic clr_counts();
      o_click = 0; o_dbl = 0; o_long = 0; o_rep = 0;
   endtask

   task automatic expect_counts(input string tag, input int c, input int d, input int l, input int r);
      check_eq({tag, "_click"}, o_click, c);
      check_eq({tag, "_dbl"},   o_dbl,   d);
      check_eq({tag, "_long"},  o_long,  l);
      check_eq({tag, "_rep"},   o_rep,   r);
   endtask

   initial begin
      model_reset();
      clr_counts();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset", {click, dbl_click, long_press, repeat_tick, busy}, 5'b0);
      rst_n = 1'b1;

      clr_counts(); drive(1, 3); drive(0, 6);
      expect_counts("single", 1, 0, 0, 0);

      clr_counts(); drive(1, 3); drive(0, 2); drive(1, 2); drive(0, 3);
      expect_counts("double", 0, 1, 0, 0);

      clr_counts(); drive(1, 20); drive(0, 2);
      expect_counts("long", 0, 0, 1, 3);

      clr_counts(); drive(1, 2); drive(0, 5);
      expect_counts("gap_exp", 1, 0, 0, 0);
      clr_counts(); drive(1, 2); drive(0, 4); drive(1, 1); drive(0, 3);
      expect_counts("gap_edge", 0, 1, 0, 0);

      clr_counts(); drive(1, 2); drive(0, 1); drive(1, 12);
      check_eq("held2_busy", busy, 1'b1);
      drive(0, 2);
      expect_counts("held2", 0, 1, 0, 0);

      // asynchronous reset mid-cycle while in a held long press
      clr_counts(); drive(1, 12);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_rst", {click, dbl_click, long_press, repeat_tick, busy}, 5'b0);
      drive(1, 2);
      #2 rst_n = 1'b1;
      clr_counts(); drive(1, 8);
      check_eq("rst_nolong8", o_long, 0);
      drive(1, 1);
      check_eq("rst_long9", o_long, 1);
      drive(0, 2);

      for (int g = 0; g < 300; g++) begin
         drive(1, $urandom_range(1, 14));
         drive(0, $urandom_range(1, 7));
      end
      drive(0, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
